// File: rtl/cv32e40p_illegal_insn_logq.sv
// cv32e40p_illegal_insn_logq: illegal-instruction event log FIFO with overflow hysteresis; CV32E40P_ILLEGAL_LOG_DEDUP_EN enables repeat suppression
module cv32e40p_illegal_insn_logq #(
  parameter int DEPTH  = 4,
  parameter int TS_W   = 32,
  parameter int DROP_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic                     is_decoding_i,
  input  logic                     illegal_insn_dec_i,
  input  logic [31:0]              hart_id_i,
  input  logic [31:0]              pc_id_i,
  output logic                     log_valid_o,
  input  logic                     log_ready_i,
  output logic [31:0]              log_pc_o,
  output logic [3:0]               log_hart_o,
  output logic [TS_W-1:0]          log_ts_o,
  output logic                     log_drop_o,
  output logic [DROP_W-1:0]        drop_cnt_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [LW-1:0] HALF = LW'(DEPTH / 2);
  typedef enum logic {NORMAL, OVERFLOW} state_e;
  state_e state_q, state_d;
  logic [LW-1:0] level_q, level_d, level_pop;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [TS_W-1:0] ts_q;
  logic [DROP_W-1:0] drop_cnt_q;
  logic ovf_q, pend_q;
  logic [31:0] pc_mem [DEPTH];
  logic [3:0] hart_mem [DEPTH];
  logic [TS_W-1:0] ts_mem [DEPTH];
  logic [DEPTH-1:0] drop_mem;
  logic ev, pop, push, drop, dup;
  logic unused_hart;
  assign unused_hart = ^hart_id_i[31:4];
`ifdef CV32E40P_ILLEGAL_LOG_DEDUP_EN
  logic last_vld_q;
  logic [31:0] last_pc_q;
  logic [3:0] last_hart_q;
  assign dup = last_vld_q && last_pc_q == pc_id_i && last_hart_q == hart_id_i[3:0];
  // remember the most recently pushed event so an immediate repeat can be suppressed
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      last_vld_q  <= 1'b0;
      last_pc_q   <= '0;
      last_hart_q <= '0;
    end else if (clr_i) begin
      last_vld_q <= 1'b0;
    end else if (push) begin
      last_vld_q  <= 1'b1;
      last_pc_q   <= pc_id_i;
      last_hart_q <= hart_id_i[3:0];
    end
`else
  assign dup = 1'b0;
`endif
  assign log_valid_o = level_q != '0;
  assign pop         = log_valid_o && log_ready_i;
  assign ev          = en_i && is_decoding_i && illegal_insn_dec_i && !dup && !clr_i;
  assign level_pop   = level_q - LW'(pop);
  assign level_d     = level_pop + LW'(push);
  assign log_pc_o    = log_valid_o ? pc_mem[rptr_q] : '0;
  assign log_hart_o  = log_valid_o ? hart_mem[rptr_q] : '0;
  assign log_ts_o    = log_valid_o ? ts_mem[rptr_q] : '0;
  assign log_drop_o  = log_valid_o && drop_mem[rptr_q];
  assign drop_cnt_o  = drop_cnt_q;
  assign level_o     = level_q;
  assign overflow_o  = ovf_q;
  // capture scheduling: a pop frees a slot first; once overflowed, drop until drained to half
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    drop    = 1'b0;
    if (state_q == NORMAL) begin
      push    = ev && (level_q != FULL || pop);
      drop    = ev && !push;
      state_d = drop ? OVERFLOW : NORMAL;
    end else begin
      drop    = ev;
      state_d = level_pop <= HALF ? NORMAL : OVERFLOW;
    end
  end
  // control state, pointers, drop accounting and free-running timestamp
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q    <= NORMAL;
      level_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      ts_q       <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (clr_i) begin
        state_q    <= NORMAL;
        level_q    <= '0;
        wptr_q     <= '0;
        rptr_q     <= '0;
        drop_cnt_q <= '0;
        ovf_q      <= 1'b0;
        pend_q     <= 1'b0;
      end else begin
        state_q <= state_d;
        level_q <= level_d;
        if (push) wptr_q <= wptr_q + AW'(1);
        if (pop) rptr_q <= rptr_q + AW'(1);
        if (drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_W'(1);
        if (drop) ovf_q <= 1'b1;
        if (drop) pend_q <= 1'b1;
        else if (push) pend_q <= 1'b0;
      end
    end
  // entry storage; the pending-drop marker tags the first entry after a loss
  always_ff @(posedge clk_i)
    if (push) begin
      pc_mem[wptr_q]   <= pc_id_i;
      hart_mem[wptr_q] <= hart_id_i[3:0];
      ts_mem[wptr_q]   <= ts_q;
      drop_mem[wptr_q] <= pend_q;
    end
endmodule

// File: tb/tb_cv32e40p_illegal_insn_logq.sv
// tb_cv32e40p_illegal_insn_logq: scoreboard bench for the illegal-instruction log FIFO
module tb_cv32e40p_illegal_insn_logq;
  localparam int DEPTH  = 4;
  localparam int TS_W   = 32;
  localparam int DROP_W = 2;
  localparam int SAT    = (1 << DROP_W) - 1;
  logic clk_i = 1'b0;
  logic rst_i, en_i, clr_i, is_decoding_i, illegal_insn_dec_i, log_ready_i;
  logic [31:0] hart_id_i, pc_id_i;
  logic log_valid_o, log_drop_o, overflow_o;
  logic [31:0] log_pc_o;
  logic [3:0] log_hart_o;
  logic [TS_W-1:0] log_ts_o;
  logic [DROP_W-1:0] drop_cnt_o;
  logic [$clog2(DEPTH):0] level_o;
  typedef struct packed {
    logic [31:0]     pc;
    logic [3:0]      hart;
    logic [TS_W-1:0] ts;
    logic            drop;
  } ent_t;
  ent_t sb[$];
  int n_vec = 0, n_err = 0, beats = 0, m_cnt = 0;
  bit m_ovf_st, m_ovf, m_pend, m_lv;
  logic [31:0] m_ts = '0, m_lpc = '0;
  logic [3:0] m_lh = '0;
  cv32e40p_illegal_insn_logq #(.DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i),
    .is_decoding_i(is_decoding_i), .illegal_insn_dec_i(illegal_insn_dec_i),
    .hart_id_i(hart_id_i), .pc_id_i(pc_id_i),
    .log_valid_o(log_valid_o), .log_ready_i(log_ready_i),
    .log_pc_o(log_pc_o), .log_hart_o(log_hart_o), .log_ts_o(log_ts_o),
    .log_drop_o(log_drop_o), .drop_cnt_o(drop_cnt_o), .level_o(level_o),
    .overflow_o(overflow_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_clear();
    sb.delete();
    m_ovf_st = 0;
    m_ovf    = 0;
    m_pend   = 0;
    m_lv     = 0;
    m_cnt    = 0;
  endtask
  task automatic tick();
    ent_t e;
    bit ev, dup;
    @(negedge clk_i);
    if (rst_i) begin
      model_clear();
      m_ts = '0;
    end
    check("valid", log_valid_o, sb.size() != 0);
    check("level", level_o, sb.size());
    check("drop_cnt", drop_cnt_o, m_cnt);
    check("overflow", overflow_o, m_ovf);
    if (sb.size() == 0) begin
      check("idle_data", {log_pc_o, log_hart_o, log_drop_o}, 0);
      check("idle_ts", log_ts_o, 0);
    end else if (log_ready_i) begin
      e = sb.pop_front();
      beats++;
      check("pc", log_pc_o, e.pc);
      check("hart", log_hart_o, e.hart);
      check("ts", log_ts_o, e.ts);
      check("drop_flag", log_drop_o, e.drop);
    end
    if (!rst_i) begin
      ev = en_i && is_decoding_i && illegal_insn_dec_i;
`ifdef CV32E40P_ILLEGAL_LOG_DEDUP_EN
      dup = m_lv && m_lpc == pc_id_i && m_lh == hart_id_i[3:0];
`else
      dup = 0;
`endif
      if (clr_i) model_clear();
      else begin
        if (ev && !dup) begin
          if (!m_ovf_st && sb.size() < DEPTH) begin
            e.pc = pc_id_i; e.hart = hart_id_i[3:0]; e.ts = m_ts; e.drop = m_pend;
            sb.push_back(e);
            m_pend = 0; m_lv = 1; m_lpc = pc_id_i; m_lh = hart_id_i[3:0];
          end else begin
            m_cnt    = m_cnt == SAT ? SAT : m_cnt + 1;
            m_ovf    = 1;
            m_pend   = 1;
            m_ovf_st = 1;
          end
        end
        if (m_ovf_st && sb.size() <= DEPTH / 2) m_ovf_st = 0;
      end
      m_ts = m_ts + 1;
    end
    @(posedge clk_i);
    #1;
  endtask
  task automatic step(input bit e, input logic [31:0] pc, input bit rdy);
    is_decoding_i      = e;
    illegal_insn_dec_i = e;
    pc_id_i            = pc;
    log_ready_i        = rdy;
    tick();
  endtask
  task automatic clear(input bit e);
    clr_i = 1;
    step(e, 32'hdead_0000, 0);
    clr_i = 0;
  endtask
  initial begin
    rst_i = 1; en_i = 1; clr_i = 0; is_decoding_i = 0; illegal_insn_dec_i = 0;
    log_ready_i = 0; hart_id_i = 3; pc_id_i = 0;
    tick(); tick();
    rst_i = 0;
    step(1, 32'h0000_0100, 1);
    repeat (2) step(0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 32'h1000 + 32'(i * 4), 0);
    repeat (3) step(0, 0, 1);
    step(1, 32'h2000, 0);
    repeat (4) step(0, 0, 1);
    clear(1);
    for (int i = 0; i < 5; i++) step(1, 32'h3000 + 32'(i * 4), 0);
    step(1, 32'h3100, 1);
    step(0, 0, 1);
    step(1, 32'h3200, 0);
    repeat (5) step(0, 0, 1);
    clear(0);
    hart_id_i = 9;
    for (int i = 0; i < 4; i++) step(1, 32'h4000 + 32'(i * 4), 0);
    step(1, 32'h4100, 1);
    repeat (6) step(0, 0, 1);
    clear(0);
    for (int i = 0; i < DEPTH + 5; i++) step(1, 32'h5000 + 32'(i * 4), 0);
    clear(1);
    step(0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 32'h6000 + 32'(i * 4), 0);
    en_i = 0;
    repeat (3) step(1, 32'h6080, 1);
    en_i = 1;
    step(1, 32'h6100, 1);
    repeat (3) step(0, 0, 1);
    clear(0);
    hart_id_i = 5;
    beats = 0;
    repeat (3) step(1, 32'h200, 1);
    step(1, 32'h204, 1);
    step(1, 32'h200, 1);
    repeat (3) step(0, 0, 1);
`ifdef CV32E40P_ILLEGAL_LOG_DEDUP_EN
    check("dedup_beats", beats, 3);
`else
    check("dedup_beats", beats, 5);
`endif
    repeat (400) begin
      is_decoding_i      = 1'($urandom_range(0, 1));
      illegal_insn_dec_i = $urandom_range(0, 2) != 0;
      en_i               = $urandom_range(0, 7) != 0;
      log_ready_i        = $urandom_range(0, 2) == 0;
      clr_i              = $urandom_range(0, 99) == 0;
      pc_id_i            = 32'h300 + 32'($urandom_range(0, 3) * 4);
      hart_id_i          = 32'($urandom_range(0, 1));
      tick();
    end
    clr_i = 0; en_i = 1;
    for (int i = 0; i < 3; i++) step(1, 32'h7000 + 32'(i * 4), 0);
    rst_i = 1;
    step(0, 0, 1);
    rst_i = 0;
    step(1, 32'h7100, 1);
    repeat (2) step(0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
